// File: rtl/config_pkg.sv
// Shared types and constants for the configuration shadow bank.
// The COMMIT and CLEAR addresses sit directly above the register window.
package config_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } cfg_state_t;

  localparam int ERR_UNMAPPED   = 0;
  localparam int ERR_DROPPED    = 1;
  localparam int ERR_INCOMPLETE = 2;
  localparam int ERR_BITS       = 3;

  function automatic int cfg_commit_addr(input int num_regs);
    return num_regs;
  endfunction

  function automatic int cfg_clear_addr(input int num_regs);
    return num_regs + 1;
  endfunction

endpackage

// File: rtl/config_addr_decode.sv
// Combinational decode of one config write into register strobes and command flags.
// Only the low ceil(log2(NUM_REGS+2)) address bits are compared; any higher set bit is unmapped.
module config_addr_decode
  import config_pkg::*;
#(
  parameter int NUM_REGS  = 8,
  parameter int ADDR_BITS = 16
) (
  input  logic                 valid_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  output logic [NUM_REGS-1:0]  reg_we_o,
  output logic                 is_commit_o,
  output logic                 is_clear_o,
  output logic                 is_unmapped_o
);

  localparam int AW = $clog2(NUM_REGS + 2);
  localparam logic [AW-1:0] COMMIT_IDX = AW'(cfg_commit_addr(NUM_REGS));
  localparam logic [AW-1:0] CLEAR_IDX  = AW'(cfg_clear_addr(NUM_REGS));

  logic [AW-1:0] idx_s;
  logic          hi_set_s;

  assign idx_s    = addr_i[AW-1:0];
  assign hi_set_s = |(addr_i >> AW);

  // Exactly one of the outputs fires for a valid write; nothing fires otherwise.
  always_comb begin
    reg_we_o      = '0;
    is_commit_o   = 1'b0;
    is_clear_o    = 1'b0;
    is_unmapped_o = 1'b0;
    if (valid_i) begin
      if (hi_set_s) begin
        is_unmapped_o = 1'b1;
      end else if (idx_s == COMMIT_IDX) begin
        is_commit_o = 1'b1;
      end else if (idx_s == CLEAR_IDX) begin
        is_clear_o = 1'b1;
      end else if (idx_s < AW'(NUM_REGS)) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          reg_we_o[r] = (idx_s == AW'(r));
        end
      end else begin
        is_unmapped_o = 1'b1;
      end
    end else begin
      reg_we_o = '0;
    end
  end

endmodule

// File: rtl/config_shadow_bank.sv
// Shadow register bank fed by config writes; a committed bank is copied atomically
// to the active registers on the first cycle the downstream datapath reports quiescence.
module config_shadow_bank
  import config_pkg::*;
#(
  parameter int                  NUM_REGS      = 8,
  parameter int                  DATA_BITS     = 64,
  parameter int                  ADDR_BITS     = 16,
  parameter logic [NUM_REGS-1:0] REQUIRED_MASK = {NUM_REGS{1'b1}}
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  input  logic [ADDR_BITS-1:0]                in_addr,
  input  logic [DATA_BITS-1:0]                in_data,
  input  logic                                i_quiesce,
  output logic [NUM_REGS-1:0][DATA_BITS-1:0]  o_active,
  output logic                                o_update,
  output logic [15:0]                         o_generation,
  output logic [NUM_REGS-1:0]                 o_written_mask,
  output logic                                o_pending,
  output logic [ERR_BITS-1:0]                 o_err
);

  logic [NUM_REGS-1:0] reg_we_s;
  logic                is_commit_s;
  logic                is_clear_s;
  logic                is_unmapped_s;
  logic                commit_ok_s;

  cfg_state_t                          state_q;
  logic [NUM_REGS-1:0][DATA_BITS-1:0]  shadow_q;
  logic [NUM_REGS-1:0][DATA_BITS-1:0]  active_q;
  logic [NUM_REGS-1:0]                 mask_q;
  logic [15:0]                         gen_q;
  logic                                update_q;
  logic                                pending_q;
  logic [ERR_BITS-1:0]                 err_q;

  config_addr_decode #(
    .NUM_REGS  (NUM_REGS),
    .ADDR_BITS (ADDR_BITS)
  ) u_decode (
    .valid_i       (in_valid),
    .addr_i        (in_addr),
    .reg_we_o      (reg_we_s),
    .is_commit_o   (is_commit_s),
    .is_clear_o    (is_clear_s),
    .is_unmapped_o (is_unmapped_s)
  );

  assign commit_ok_s = ((mask_q & REQUIRED_MASK) == REQUIRED_MASK);

  // Commit FSM with the shadow bank, active bank and status registers it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      active_q  <= '0;
      mask_q    <= '0;
      gen_q     <= 16'h0000;
      update_q  <= 1'b0;
      pending_q <= 1'b0;
      err_q     <= '0;
    end else begin
      update_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (is_commit_s) begin
            if (commit_ok_s) begin
              state_q   <= ARMED;
              pending_q <= 1'b1;
            end else begin
              err_q[ERR_INCOMPLETE] <= 1'b1;
            end
          end else if (is_clear_s) begin
            mask_q <= '0;
            err_q  <= '0;
          end else if (is_unmapped_s) begin
            err_q[ERR_UNMAPPED] <= 1'b1;
          end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
              if (reg_we_s[r]) begin
                shadow_q[r] <= in_data;
                mask_q[r]   <= 1'b1;
              end
            end
          end
        end
        ARMED: begin
          // Any write while armed is dropped, including in the apply cycle.
          if (in_valid) begin
            err_q[ERR_DROPPED] <= 1'b1;
          end
          if (i_quiesce) begin
            active_q  <= shadow_q;
            update_q  <= 1'b1;
            gen_q     <= gen_q + 16'd1;
            mask_q    <= '0;
            pending_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_active       = active_q;
  assign o_update       = update_q;
  assign o_generation   = gen_q;
  assign o_written_mask = mask_q;
  assign o_pending      = pending_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_config_shadow_bank.sv
// Bench for config_shadow_bank with NUM_REGS=4: vector table for single-cycle behaviour,
// hand sequences for delayed commit, generation wrap and reset abort; applies checked via a queue.
module tb_config_shadow_bank;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic [15:0]          in_addr = 16'h0000;
  logic [63:0]          in_data = 64'h0;
  logic                 i_quiesce = 1'b0;
  logic [3:0][63:0]     o_active;
  logic                 o_update;
  logic [15:0]          o_generation;
  logic [3:0]           o_written_mask;
  logic                 o_pending;
  logic [2:0]           o_err;

  config_shadow_bank #(
    .NUM_REGS      (4),
    .DATA_BITS     (64),
    .ADDR_BITS     (16),
    .REQUIRED_MASK (4'b1111)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .i_quiesce      (i_quiesce),
    .o_active       (o_active),
    .o_update       (o_update),
    .o_generation   (o_generation),
    .o_written_mask (o_written_mask),
    .o_pending      (o_pending),
    .o_err          (o_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [15:0] a;
    logic [63:0] d;
    logic        q;
    logic [3:0]  mask;
    logic [2:0]  err;
    logic        pend;
    logic        upd;
    logic [15:0] gen;
  } vec_t;

  typedef struct packed {
    logic [3:0][63:0] act;
    logic [15:0]      gen;
  } sb_t;

  int checks = 0;
  int errors = 0;
  sb_t sb_q[$];
  sb_t mon_e;
  logic [3:0][63:0] shadow_m = '0;
  vec_t vecs[16];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [63:0] d, input logic q);
    @(negedge clk);
    in_valid  = v;
    in_addr   = a;
    in_data   = d;
    i_quiesce = q;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic [63:0] d);
    drive(1'b1, 16'(idx), d, 1'b0);
    shadow_m[idx] = d;
  endtask

  // Every o_update pulse must match the oldest accepted commit.
  always @(negedge clk) begin
    if (o_update === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update got=1 expected=0 at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_active", o_active, mon_e.act);
        chk("sb_generation", o_generation, mon_e.gen);
      end
    end
  end

  initial begin
    vecs[0]  = '{1'b1, 16'd0, 64'h11, 1'b1, 4'h1, 3'b000, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 16'd1, 64'h22, 1'b1, 4'h3, 3'b000, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 16'd2, 64'h33, 1'b1, 4'h7, 3'b000, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 16'd3, 64'h44, 1'b1, 4'hF, 3'b000, 1'b0, 1'b0, 16'd0};
    vecs[4]  = '{1'b1, 16'd4, 64'hDEAD, 1'b1, 4'hF, 3'b000, 1'b1, 1'b0, 16'd0};
    vecs[5]  = '{1'b0, 16'd0, 64'h0, 1'b1, 4'h0, 3'b000, 1'b0, 1'b1, 16'd1};
    vecs[6]  = '{1'b0, 16'd0, 64'h0, 1'b0, 4'h0, 3'b000, 1'b0, 1'b0, 16'd1};
    vecs[7]  = '{1'b1, 16'd0, 64'h55, 1'b1, 4'h1, 3'b000, 1'b0, 1'b0, 16'd1};
    vecs[8]  = '{1'b1, 16'd1, 64'h66, 1'b1, 4'h3, 3'b000, 1'b0, 1'b0, 16'd1};
    vecs[9]  = '{1'b1, 16'd2, 64'h77, 1'b1, 4'h7, 3'b000, 1'b0, 1'b0, 16'd1};
    vecs[10] = '{1'b1, 16'd4, 64'h0, 1'b1, 4'h7, 3'b100, 1'b0, 1'b0, 16'd1};
    vecs[11] = '{1'b0, 16'd0, 64'h0, 1'b1, 4'h7, 3'b100, 1'b0, 1'b0, 16'd1};
    vecs[12] = '{1'b1, 16'd9, 64'h99, 1'b0, 4'h7, 3'b101, 1'b0, 1'b0, 16'd1};
    vecs[13] = '{1'b1, 16'd5, 64'h0, 1'b0, 4'h0, 3'b000, 1'b0, 1'b0, 16'd1};
    vecs[14] = '{1'b1, 16'd6, 64'h0, 1'b0, 4'h0, 3'b001, 1'b0, 1'b0, 16'd1};
    vecs[15] = '{1'b1, 16'd5, 64'h0, 1'b0, 4'h0, 3'b000, 1'b0, 1'b0, 16'd1};

    #12;
    chk("rst_active", o_active, 256'h0);
    chk("rst_update", o_update, 1'b0);
    chk("rst_generation", o_generation, 16'h0);
    chk("rst_mask", o_written_mask, 4'h0);
    chk("rst_pending", o_pending, 1'b0);
    chk("rst_err", o_err, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].v && vecs[i].a < 16'd4) begin
        shadow_m[vecs[i].a[1:0]] = vecs[i].d;
      end
      if (vecs[i].pend) begin
        sb_q.push_back('{shadow_m, vecs[i].gen + 16'd1});
      end
      drive(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].q);
      chk($sformatf("vec%0d_mask", i), o_written_mask, vecs[i].mask);
      chk($sformatf("vec%0d_err", i), o_err, vecs[i].err);
      chk($sformatf("vec%0d_pending", i), o_pending, vecs[i].pend);
      chk($sformatf("vec%0d_update", i), o_update, vecs[i].upd);
      chk($sformatf("vec%0d_generation", i), o_generation, vecs[i].gen);
    end
    chk("incomplete_active_kept", o_active, {64'h44, 64'h33, 64'h22, 64'h11});

    // Commit held off by quiesce; a write during the wait is dropped.
    for (int i = 0; i < 4; i++) wr(i, 64'h101 * (i + 1));
    sb_q.push_back('{shadow_m, 16'd2});
    drive(1'b1, 16'd4, 64'h0, 1'b0);
    chk("wait_pending_set", o_pending, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) drive(1'b1, 16'd1, 64'hAA, 1'b0);
      else        drive(1'b0, 16'd0, 64'h0, 1'b0);
      chk($sformatf("wait%0d_pending", c), o_pending, 1'b1);
      chk($sformatf("wait%0d_update", c), o_update, 1'b0);
    end
    chk("dropped_err", o_err, 3'b010);
    chk("dropped_mask", o_written_mask, 4'hF);
    drive(1'b0, 16'd0, 64'h0, 1'b1);
    chk("quiesce_update", o_update, 1'b1);
    chk("quiesce_pending", o_pending, 1'b0);
    chk("quiesce_reg1", o_active[1], 64'h202);
    chk("quiesce_generation", o_generation, 16'd2);
    drive(1'b0, 16'd0, 64'h0, 1'b0);
    chk("quiesce_update_end", o_update, 1'b0);

    // Generation wrap.
    for (int i = 0; i < 4; i++) wr(i, 64'hA0 + 64'(i));
    @(negedge clk);
    force dut.gen_q = 16'hFFFF;
    #1;
    release dut.gen_q;
    #1;
    chk("wrap_preload", o_generation, 16'hFFFF);
    sb_q.push_back('{shadow_m, 16'h0000});
    drive(1'b1, 16'd4, 64'h0, 1'b1);
    drive(1'b0, 16'd0, 64'h0, 1'b1);
    chk("wrap_update", o_update, 1'b1);
    chk("wrap_generation", o_generation, 16'h0000);

    // Reset while armed aborts the commit.
    for (int i = 0; i < 4; i++) wr(i, 64'hC0 + 64'(i));
    drive(1'b1, 16'd4, 64'h0, 1'b0);
    chk("abort_armed", o_pending, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_active", o_active, 256'h0);
    chk("abort_pending", o_pending, 1'b0);
    chk("abort_generation", o_generation, 16'h0);
    chk("abort_update", o_update, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 16'd0, 64'h0, 1'b1);
      chk($sformatf("post_rst%0d_update", c), o_update, 1'b0);
      chk($sformatf("post_rst%0d_active", c), o_active, 256'h0);
    end

    drive(1'b0, 16'd0, 64'h0, 1'b0);
    chk("sb_drained", 256'(sb_q.size()), 256'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_shadow_bank.md
Name: config_shadow_bank

Overview:
Consumer stage placed on one `configs[I]` output of the global configuration block. It decodes the stream of (addr, data, valid) config writes into a bank of shadow registers. On an explicit commit, and only when the downstream datapath reports quiescence, it transfers the whole bank atomically to active registers. This stops the datapath from ever seeing a half-written configuration.

Parameters:
- NUM_REGS, 8, number of 64-bit configuration registers in the bank (1..64)
- DATA_BITS, AXIL_DATA_BITS (64), width of each register and of `in.data`
- REQUIRED_MASK, all ones (NUM_REGS bits), registers that must be written since the last commit/clear before a commit is accepted

Ports:
- clk, input, 1, core clock
- rst_n, input, 1, asynchronous active-low reset
- in, config_i.s, addr/data/valid, incoming config writes; valid is a 1-cycle qualifier; there is no backpressure
- i_quiesce, input, 1, downstream idle; a commit may be applied in any cycle this is high
- o_active, output, NUM_REGS x DATA_BITS, active configuration driven to the datapath
- o_update, output, 1, 1-cycle pulse in the cycle after active registers change
- o_generation, output, 16, count of applied commits; wraps modulo 2^16
- o_written_mask, output, NUM_REGS, shadow registers written since the last commit/clear
- o_pending, output, 1, high while a commit is waiting for i_quiesce
- o_err, output, 3, sticky error flags: [0] unmapped address, [1] write dropped while pending, [2] commit rejected because incomplete

Behaviour:
- Address map on `in.addr`:
  - 0..NUM_REGS-1: shadow registers
  - NUM_REGS: COMMIT; data is ignored
  - NUM_REGS+1: CLEAR; data is ignored
  - anything higher is unmapped
- Reset (asynchronous assert; deassert follows the codebase reset-resync): all outputs, shadow registers, state and counters go to 0; state = IDLE.
- State machine has two states, IDLE and ARMED.
- Handling of a write sampled (in.valid=1) in IDLE:
  - Register address: shadow[a] <= data and mask[a] <= 1 on the same edge. The shadow write is visible internally the next cycle. o_active is unaffected.
  - COMMIT with (mask & REQUIRED_MASK) == REQUIRED_MASK: go to ARMED and set o_pending=1 on the next edge.
  - COMMIT with an incomplete mask: stay in IDLE, set o_err[2]; mask is unchanged.
  - CLEAR: mask <= 0 and o_err <= 0. Shadow contents are retained.
  - Unmapped address: set o_err[0]; nothing else changes.
- Behaviour in ARMED:
  - On any edge with i_quiesce=1: o_active <= shadow (all registers on one edge), o_update <= 1 for one cycle, o_generation += 1, mask <= 0, o_pending <= 0, state -> IDLE.
  - Minimum latency is 2 edges: the COMMIT is sampled at E0, and o_active changes at E1 if i_quiesce=1 during the E0..E1 cycle.
  - Every in.valid write sampled while in ARMED is dropped and sets o_err[1]. This covers register, COMMIT, CLEAR and unmapped addresses, and includes the cycle in which the apply happens. The upstream driver must poll o_pending.
  - ARMED has no timeout. It is left only on quiesce or reset.
- Width rules:
  - Address compare uses the low ceil(log2(NUM_REGS+2)) bits of in.addr. Higher set bits mark the write as unmapped.
  - o_generation wraps from 0xFFFF to 0x0000 with no flag.
- A reset asserted while in ARMED aborts the commit. o_active returns to 0 and no o_update pulse is produced.
- The error flags are sticky. They clear only on CLEAR or reset.

Decomposition:
- Shared package `config_pkg` holds:
  - cfg_state_t enum (IDLE, ARMED)
  - error bit index constants (ERR_UNMAPPED=0, ERR_DROPPED=1, ERR_INCOMPLETE=2)
  - function `cfg_commit_addr(NUM_REGS)` and function `cfg_clear_addr(NUM_REGS)`
- Sub-module `config_addr_decode` (combinational) decodes in.addr/in.valid into one-hot reg_we[NUM_REGS], is_commit, is_clear and is_unmapped. The registered bank and FSM stay in the top module.

Test Plan:
1. Reset, then NUM_REGS=4 with REQUIRED_MASK=4'b1111. Write regs 0..3 = 0x11..0x44, then COMMIT with i_quiesce=1 -> o_update pulses 2 edges after the COMMIT; o_active = {0x44,0x33,0x22,0x11}; o_generation=1; o_written_mask=0.
2. Write regs 0..2 only, then COMMIT -> o_err[2]=1; state remains IDLE; o_active unchanged; o_generation unchanged.
3. Full writes, COMMIT with i_quiesce=0 for 10 cycles, write reg 1=0xAA at cycle 5, then raise i_quiesce -> o_pending=1 during the wait; o_err[1]=1; applied reg 1 is the pre-commit value; o_update pulses one edge after i_quiesce rises.
4. Write to address NUM_REGS+5 -> o_err[0]=1. Then write CLEAR -> o_err=0 and o_written_mask=0.
5. Preload o_generation to 0xFFFF by repeated commits (or force), then commit once more -> o_generation=0x0000 and o_update still pulses.
6. Assert rst_n low mid-ARMED, asynchronously between edges -> o_active, o_pending and o_generation read 0 immediately; no o_update after deassert.
